// File: rtl/bch_scoreboard.sv
// bch_scoreboard
//   Receive-side self-checking scoreboard for the BCH encode/channel/decode
//   path. Words accepted by the encoder are queued with their injected error
//   count. Each decoder output pops the oldest entry and is compared against
//   it one cycle later. Pass/fail flags and statistics are kept in hardware.
//
//   Optional feature macro: BCH_SCOREBOARD_STATS_EN
//     defined   : words_ok / words_uncorr saturating counters are built
//     undefined : both outputs are tied to zero
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   clear        synchronous flush of FIFO, flags, counters and FSM
//   vdin/din/nerr    push strobe, encoder data word, injected bit flips
//   vdout/dout       pop strobe, decoder output word
//   wrong_now    one-cycle pulse on a correctable-word mismatch
//   wrong        sticky mismatch flag
//   overflow     sticky push-while-full flag
//   underflow    sticky pop-while-empty flag
//   pending      FIFO occupancy
//   words_ok     words compared equal
//   words_uncorr words whose error count exceeded T (not checked)
module bch_scoreboard #(
   parameter int K     = 11,
   parameter int T     = 5,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       clear,
   input  logic                       vdin,
   input  logic [K-1:0]               din,
   input  logic [$clog2(T+2)-1:0]     nerr,
   input  logic                       vdout,
   input  logic [K-1:0]               dout,
   output logic                       wrong_now,
   output logic                       wrong,
   output logic                       overflow,
   output logic                       underflow,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic [31:0]                words_ok,
   output logic [15:0]                words_uncorr
);

   localparam int NW = $clog2(T+2);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [NW-1:0] T_N  = NW'(T);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t          state, state_nxt;
   logic [K-1:0]    din_mem  [DEPTH];
   logic [NW-1:0]   nerr_mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;

   logic            active_p0, push_p0, pop_p0, ovf_p0, udf_p0;
   logic            mism_p0, unc_p0;

   // Stage p0: strobe qualification and compare against the FIFO head
   always_comb begin
      active_p0 = (state != HALT) && !clear;
      pop_p0    = active_p0 && vdout && (count != '0);
      udf_p0    = active_p0 && vdout && (count == '0);
      // A pop in the same cycle frees a slot, so push+pop is legal when full.
      push_p0   = active_p0 && vdin && ((count != FULL) || pop_p0);
      ovf_p0    = active_p0 && vdin && (count == FULL) && !pop_p0;
      mism_p0   = (dout != din_mem[rd_ptr]);
      unc_p0    = (nerr_mem[rd_ptr] > T_N);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (udf_p0)                        state_nxt = HALT;
            else if (active_p0 && vdin)        state_nxt = RUN;
         end
         RUN: begin
            if (wrong || overflow || underflow) state_nxt = HALT;
         end
         default: state_nxt = HALT;
      endcase
      if (clear) state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   // FIFO storage is data only and is never reset.
   always_ff @(posedge clk) begin
      if (push_p0) begin
         din_mem[wr_ptr]  <= din;
         nerr_mem[wr_ptr] <= nerr;
      end
   end

   // Stage p1: pointers, occupancy and registered compare results
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wrong_now <= 1'b0;
         wrong     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (clear) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         wrong_now <= 1'b0;
         wrong     <= 1'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (push_p0) wr_ptr <= wr_ptr + AW'(1);
         if (pop_p0)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_p0, pop_p0})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         // A pop taken in the last RUN cycle still reports its result,
         // even though the FSM is in HALT when that result appears.
         wrong_now <= pop_p0 && !unc_p0 && mism_p0;
         if (pop_p0 && !unc_p0 && mism_p0) wrong     <= 1'b1;
         if (ovf_p0)                       overflow  <= 1'b1;
         if (udf_p0)                       underflow <= 1'b1;
      end
   end

   assign pending = count;

`ifdef BCH_SCOREBOARD_STATS_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == '1) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         words_ok     <= '0;
         words_uncorr <= '0;
      end else if (clear) begin
         words_ok     <= '0;
         words_uncorr <= '0;
      end else if (pop_p0) begin
         if (unc_p0)        words_uncorr <= sat_inc16(words_uncorr);
         else if (!mism_p0) words_ok     <= sat_inc32(words_ok);
      end
   end
`else
   assign words_ok     = '0;
   assign words_uncorr = '0;
`endif

endmodule

// File: tb/tb_bch_scoreboard.sv
// tb_bch_scoreboard
//   Self-checking bench for bch_scoreboard. A transaction-level model (a
//   queue of expected entries plus flag/counter bookkeeping) predicts every
//   output after each clock edge; directed scenarios and a random stream
//   are compared against it.
module tb_bch_scoreboard;

   localparam int K     = 11;
   localparam int T     = 5;
   localparam int DEPTH = 8;
`ifdef BCH_SCOREBOARD_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        clear = 1'b0;
   logic        vdin = 1'b0;
   logic [10:0] din = '0;
   logic [2:0]  nerr = '0;
   logic        vdout = 1'b0;
   logic [10:0] dout = '0;
   logic        wrong_now, wrong, overflow, underflow;
   logic [3:0]  pending;
   logic [31:0] words_ok;
   logic [15:0] words_uncorr;

   int tests = 0;
   int fails = 0;

   bch_scoreboard #(.K(K), .T(T), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n), .clear(clear),
      .vdin(vdin), .din(din), .nerr(nerr),
      .vdout(vdout), .dout(dout),
      .wrong_now(wrong_now), .wrong(wrong), .overflow(overflow),
      .underflow(underflow), .pending(pending),
      .words_ok(words_ok), .words_uncorr(words_uncorr)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct { logic [10:0] d; int n; } ent_t;
   ent_t        q[$];
   bit          m_idle, m_halt, m_wrong, m_wn, m_ovf, m_udf;
   int unsigned m_ok, m_unc;

   task automatic model_reset();
      q.delete();
      m_idle = 1; m_halt = 0; m_wrong = 0; m_wn = 0; m_ovf = 0; m_udf = 0;
      m_ok = 0; m_unc = 0;
   endtask

   task automatic model_step(input bit vi, input logic [10:0] d, input int n,
                             input bit vo, input logic [10:0] o, input bit cl);
      bit   any_flag;
      bit   popped;
      ent_t e;
      any_flag = m_wrong || m_ovf || m_udf;
      popped   = 0;
      m_wn     = 0;
      if (cl) begin
         model_reset();
         return;
      end
      if (m_halt) return;
      if (vo) begin
         if (q.size() == 0) m_udf = 1;
         else begin
            e = q.pop_front();
            popped = 1;
         end
      end
      if (vi) begin
         if (q.size() < DEPTH) q.push_back('{d: d, n: n});
         else                  m_ovf = 1;
      end
      if (popped) begin
         if (e.n > T) begin
            if (m_unc < 65535) m_unc++;
         end else if (o != e.d) begin
            m_wn = 1; m_wrong = 1;
         end else begin
            if (m_ok != 32'hFFFF_FFFF) m_ok++;
         end
      end
      if (m_idle) begin
         if (vo)      m_halt = 1;
         else if (vi) m_idle = 0;
      end else if (any_flag) begin
         m_halt = 1;
      end
   endtask

   function automatic logic [55:0] expv();
      return {m_wn, m_wrong, m_ovf, m_udf, 4'(q.size()),
              STATS ? 32'(m_ok) : 32'd0, STATS ? 16'(m_unc) : 16'd0};
   endfunction

   function automatic logic [55:0] obsv();
      return {wrong_now, wrong, overflow, underflow, pending, words_ok, words_uncorr};
   endfunction

   // one clock cycle: apply inputs, advance model at the edge, settle
   task automatic drive(input bit vi, input logic [10:0] d, input logic [2:0] n,
                        input bit vo, input logic [10:0] o, input bit cl);
      vdin = vi; din = d; nerr = n; vdout = vo; dout = o; clear = cl;
      @(posedge clk);
      model_step(vi, d, int'(n), vo, o, cl);
      #1;
   endtask

   task automatic do_reset();
      vdin = 0; vdout = 0; clear = 0;
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      tests++;
      if (obsv() !== 56'd0) begin
         fails++; $display("FAIL reset_state: got %h required %h", obsv(), 56'd0);
      end
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 0, 0, 0);
         tests++;
         if (obsv() !== expv()) begin
            fails++; $display("FAIL reset_idle: got %h required %h", obsv(), expv());
         end
      end
   endtask

   task automatic test_in_order();
      logic [10:0] dv[3];
      logic [2:0]  nv[3];
      dv = '{11'h001, 11'h2AA, 11'h7FF};
      nv = '{3'd0, 3'd2, 3'd5};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1, dv[i], nv[i], 0, 0, 0);
         tests++;
         if (obsv() !== expv()) begin
            fails++; $display("FAIL inorder_push%0d: got %h required %h", i, obsv(), expv());
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1, dv[i], 0);
         tests++;
         if (obsv() !== expv()) begin
            fails++; $display("FAIL inorder_pop%0d: got %h required %h", i, obsv(), expv());
         end
      end
      tests++;
      if (words_ok !== (STATS ? 32'd3 : 32'd0) || wrong !== 1'b0 || pending !== 4'd0) begin
         fails++;
         $display("FAIL inorder_totals: got ok=%0d wrong=%b pending=%0d required ok=%0d wrong=0 pending=0",
                  words_ok, wrong, pending, STATS ? 3 : 0);
      end
      // still in RUN: a further push is accepted
      drive(1, 11'h123, 0, 0, 0, 0);
      tests++;
      if (pending !== 4'd1) begin
         fails++; $display("FAIL inorder_run: got pending=%0d required 1", pending);
      end
   endtask

   task automatic test_mismatch();
      do_reset();
      drive(1, 11'h155, 3'd1, 0, 0, 0);
      drive(1, 11'h0AA, 3'd0, 0, 0, 0);
      drive(0, 0, 0, 1, 11'h154, 0);
      tests++;
      if (wrong_now !== 1'b1 || wrong !== 1'b1 || obsv() !== expv()) begin
         fails++; $display("FAIL mismatch_pulse: got %h required %h", obsv(), expv());
      end
      // pop in the wrong_now cycle is still compared and counted
      drive(0, 0, 0, 1, 11'h0AA, 0);
      tests++;
      if (wrong_now !== 1'b0 || words_ok !== (STATS ? 32'd1 : 32'd0) || obsv() !== expv()) begin
         fails++; $display("FAIL mismatch_late_pop: got %h required %h", obsv(), expv());
      end
      for (int i = 0; i < 4; i++) begin
         drive(1, 11'(i * 77), 3'd0, i[0], 11'h0, 0);
         tests++;
         if (pending !== 4'd0 || obsv() !== expv()) begin
            fails++; $display("FAIL halt_frozen%0d: got %h required %h", i, obsv(), expv());
         end
      end
   endtask

   task automatic test_uncorr();
      do_reset();
      drive(1, 11'h0F0, 3'd6, 0, 0, 0);
      drive(0, 0, 0, 1, 11'h000, 0);
      drive(0, 0, 0, 0, 0, 0);
      tests++;
      if (words_uncorr !== (STATS ? 16'd1 : 16'd0) || wrong !== 1'b0 || obsv() !== expv()) begin
         fails++; $display("FAIL uncorr: got %h required %h", obsv(), expv());
      end
   endtask

   task automatic test_full();
      logic [10:0] first;
      do_reset();
      first = 11'h0;
      for (int i = 0; i < DEPTH; i++) begin
         logic [10:0] d;
         d = 11'($urandom);
         if (i == 0) first = d;
         drive(1, d, 3'd0, 0, 0, 0);
      end
      drive(1, 11'h3A5, 3'd0, 1, first, 0);
      tests++;
      if (pending !== 4'd8 || overflow !== 1'b0 || obsv() !== expv()) begin
         fails++; $display("FAIL full_pushpop: got %h required %h", obsv(), expv());
      end
      drive(1, 11'h111, 3'd0, 0, 0, 0);
      tests++;
      if (overflow !== 1'b1 || obsv() !== expv()) begin
         fails++; $display("FAIL full_overflow: got %h required %h", obsv(), expv());
      end
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 11'h222, 3'd0, 1, 11'h0, 0);
         tests++;
         if (pending !== 4'd8 || obsv() !== expv()) begin
            fails++; $display("FAIL full_halt%0d: got %h required %h", i, obsv(), expv());
         end
      end
   endtask

   task automatic test_underflow_clear();
      do_reset();
      drive(0, 0, 0, 1, 11'h0, 0);
      tests++;
      if (underflow !== 1'b1 || obsv() !== expv()) begin
         fails++; $display("FAIL underflow_set: got %h required %h", obsv(), expv());
      end
      drive(1, 11'h055, 3'd0, 0, 0, 0);
      tests++;
      if (pending !== 4'd0 || obsv() !== expv()) begin
         fails++; $display("FAIL underflow_halt: got %h required %h", obsv(), expv());
      end
      drive(1, 11'h077, 3'd0, 1, 11'h0, 1);
      tests++;
      if (obsv() !== 56'd0) begin
         fails++; $display("FAIL clear_state: got %h required %h", obsv(), 56'd0);
      end
      drive(1, 11'h3C3, 3'd0, 0, 0, 0);
      drive(0, 0, 0, 1, 11'h3C3, 0);
      tests++;
      if (words_ok !== (STATS ? 32'd1 : 32'd0) || wrong !== 1'b0 || obsv() !== expv()) begin
         fails++; $display("FAIL clear_resume: got %h required %h", obsv(), expv());
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1, 11'($urandom), 3'($urandom_range(0, 6)), 0, 0, 0);
      for (int i = 0; i < 24; i++) begin
         drive(1, 11'($urandom), 3'($urandom_range(0, 6)), 1, q[0].d, 0);
         tests++;
         if (pending !== 4'd1 || obsv() !== expv()) begin
            fails++; $display("FAIL b2b%0d: got %h required %h", i, obsv(), expv());
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 4; i++) drive(1, 11'(i + 5), 3'd0, 0, 0, 0);
      tests++;
      if (pending !== 4'd4) begin
         fails++; $display("FAIL async_pre: got pending=%0d required 4", pending);
      end
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      tests++;
      if (obsv() !== 56'd0) begin
         fails++; $display("FAIL async_reset: got %h required %h", obsv(), 56'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      drive(1, 11'h600, 3'd0, 0, 0, 0);
      drive(0, 0, 0, 1, 11'h600, 0);
      tests++;
      if (obsv() !== expv()) begin
         fails++; $display("FAIL async_resume: got %h required %h", obsv(), expv());
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int r = 0; r < 5; r++) begin
         drive(0, 0, 0, 0, 0, 1);
         for (int c = 0; c < 150; c++) begin
            bit          vi, vo, cl;
            logic [10:0] d, o;
            logic [2:0]  n;
            vi = ($urandom_range(0, 99) < 60);
            vo = ($urandom_range(0, 99) < 55);
            cl = ($urandom_range(0, 199) == 0);
            d  = 11'($urandom);
            n  = 3'($urandom_range(0, 6));
            if (q.size() > 0 && $urandom_range(0, 99) < 97) o = q[0].d;
            else                                           o = 11'($urandom);
            drive(vi, d, n, vo, o, cl);
            tests++;
            if (obsv() !== expv()) begin
               fails++; $display("FAIL random r%0d c%0d: got %h required %h", r, c, obsv(), expv());
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_in_order();
      test_mismatch();
      test_uncorr();
      test_full();
      test_underflow_clear();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
